// File: rtl/uart_receiver.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : uart_receiver
//  Purpose  : UART receive stage: 2-FF RX synchroniser, 16x oversampling,
//             mid-bit sampling of an 8-bit LSB-first frame, stop-bit check.
//             Define UART_RX_PARITY_EN to add an even-parity bit before stop.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_data_valid,
  output logic       o_frame_err,
  output logic       o_parity_err
);

  localparam int            DIV       = CLK_FREQ_HZ / (BAUD_RATE * 16);
  localparam int            PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  generate
    if (DIV < 1) begin : g_div_invalid
      $error("uart_receiver: CLK_FREQ_HZ / (BAUD_RATE*16) must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, rx_s_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            tick;
  logic            par_bad;

`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            perr_q, perr_d;
  assign par_bad      = (^shift_q) ^ par_q;
  assign o_parity_err = perr_q;
`else
  assign par_bad      = 1'b0;
  assign o_parity_err = 1'b0;
`endif

  assign tick            = (presc_q == PRESC_MAX);
  assign o_rx_data       = data_q;
  assign o_rx_data_valid = valid_q;
  assign o_frame_err     = ferr_q;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= S_IDLE;
      presc_q <= '0;
      cnt_q   <= 4'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= i_rx;
      rx_s_q  <= sync1_q;
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        // Restarting the prescaler aligns every tick to the start edge.
        if (!rx_s_q) begin
          state_d = S_START;
          presc_d = '0;
          cnt_d   = 4'd0;
          idx_d   = 3'd0;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = 4'd0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            par_d   = rx_s_q;
            state_d = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            // A low stop bit outranks any parity problem.
            if (!rx_s_q) begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
              perr_d  = 1'b1;
`endif
              state_d = S_IDLE;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_receiver
//  Purpose  : Self-checking bench for uart_receiver (16 clocks per bit);
//             frame-level expected-event model plus directed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + 7 + 16 * 10 + 1;
  localparam int FRAME_CYC = 11 * BIT;
`else
  localparam int LAT = 2 + 7 + 16 * 9 + 1;
  localparam int FRAME_CYC = 10 * BIT;
`endif
  localparam int EV_VALID = 0;
  localparam int EV_FERR  = 1;
  localparam int EV_PERR  = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk  = 1'b0;
  logic       nrst = 1'b0;
  logic       rx   = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;

  uart_receiver #(
    .CLK_FREQ_HZ (1_843_200),
    .BAUD_RATE   (115200)
  ) dut (
    .i_clk           (clk),
    .i_nrst          (nrst),
    .i_rx            (rx),
    .o_rx_data       (rx_data),
    .o_rx_data_valid (rx_valid),
    .o_frame_err     (frame_err),
    .o_parity_err    (parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  ev_t        evq[$];
  logic [7:0] exp_data = 8'h00;
  int         vcyc[$];
  logic [7:0] vdata[$];
  int         n_ferr = 0;
  int         n_perr = 0;
  bit         ev_v, ev_f, ev_p;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle comparison against the expected-event queue.
  always @(negedge clk) begin
    ev_v = 1'b0;
    ev_f = 1'b0;
    ev_p = 1'b0;
    if (!nrst) begin
      check("reset data", rx_data, 8'h00);
      check("reset valid", rx_valid, 1'b0);
      check("reset frame_err", frame_err, 1'b0);
      check("reset parity_err", parity_err, 1'b0);
    end else begin
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        check("missed event cycle", cyc, evq[0].cyc);
        void'(evq.pop_front());
      end
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        ev_v = (evq[0].kind == EV_VALID);
        ev_f = (evq[0].kind == EV_FERR);
        ev_p = (evq[0].kind == EV_PERR);
        if (ev_v) exp_data = evq[0].data;
        void'(evq.pop_front());
      end
      check("valid", rx_valid, ev_v);
      check("frame_err", frame_err, ev_f);
      check("parity_err", parity_err, ev_p);
      check("rx_data", rx_data, exp_data);
    end
    if (rx_valid === 1'b1) begin
      vcyc.push_back(cyc);
      vdata.push_back(rx_data);
    end
    if (frame_err === 1'b1) n_ferr++;
    if (parity_err === 1'b1) n_perr++;
  end

  task automatic drive_bit(input logic b, input int n);
    repeat (n) begin
      @(negedge clk);
      rx = b;
    end
  endtask

  // Drives one frame and queues the outcome the receiver must report.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            output int a);
    ev_t e;
    @(negedge clk);
    rx = 1'b0;
    a = cyc + 1;
    e.cyc  = a + LAT;
    e.data = d;
    if (!stop_b) e.kind = EV_FERR;
`ifdef UART_RX_PARITY_EN
    else if ((^d) ^ par_b) e.kind = EV_PERR;
`endif
    else e.kind = EV_VALID;
    evq.push_back(e);
    repeat (BIT - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b, BIT);
`else
    if (par_b === 1'bx) rx = 1'b1;
`endif
    drive_bit(stop_b, BIT);
  endtask

  int         a0, a1, nv, nf, np;
  logic [7:0] d;
  logic [7:0] c6;
  logic       stop_b, par_b;
  int         gap;

  initial begin
    // Reset state.
    repeat (5) @(negedge clk);
    check("init data", rx_data, 8'h00);
    check("init valid", rx_valid, 1'b0);
    nrst = 1'b1;
    drive_bit(1'b1, 20);

    // Start-bit glitch, then a clean byte.
    nv = vcyc.size();
    nf = n_ferr;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 32);
    check("glitch no valid", vcyc.size() - nv, 0);
    check("glitch no ferr", n_ferr - nf, 0);
    send_frame(8'h3C, 1'b1, ^8'h3C, a0);
    drive_bit(1'b1, BIT);
    check("after glitch data", rx_data, 8'h3C);

    // 0x55: single pulse at fixed latency.
    nv = vcyc.size();
    nf = n_ferr;
    send_frame(8'h55, 1'b1, ^8'h55, a0);
    drive_bit(1'b1, BIT);
    check("0x55 pulse count", vcyc.size() - nv, 1);
    if (vcyc.size() > nv) begin
`ifdef UART_RX_PARITY_EN
      check("0x55 latency", vcyc[vcyc.size() - 1] - a0, 170);
`else
      check("0x55 latency", vcyc[vcyc.size() - 1] - a0, 154);
`endif
    end
    check("0x55 data", rx_data, 8'h55);
    check("0x55 no ferr", n_ferr - nf, 0);

    // Framing error followed by a long break.
    nv = vcyc.size();
    nf = n_ferr;
    send_frame(8'hA3, 1'b0, ^8'hA3, a0);
    drive_bit(1'b0, 40 * BIT);
    check("ferr count", n_ferr - nf, 1);
    check("ferr no valid", vcyc.size() - nv, 0);
    check("ferr data held", rx_data, 8'h55);
    drive_bit(1'b1, 2 * BIT);
    send_frame(8'h0F, 1'b1, ^8'h0F, a0);
    drive_bit(1'b1, BIT);
    check("after break data", rx_data, 8'h0F);

    // Reset during data bit 4 of 0xC6.
    c6 = 8'hC6;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(c6[i], BIT);
    drive_bit(c6[4], BIT / 2);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check("mid reset data", rx_data, 8'h00);
    check("mid reset valid", rx_valid, 1'b0);
    check("mid reset ferr", frame_err, 1'b0);
    check("mid reset perr", parity_err, 1'b0);
    evq.delete();
    exp_data = 8'h00;
    drive_bit(1'b1, 10);
    nrst = 1'b1;
    drive_bit(1'b1, BIT);
    send_frame(8'h81, 1'b1, ^8'h81, a0);
    drive_bit(1'b1, BIT);
    check("after reset data", rx_data, 8'h81);

    // Back-to-back frames with no idle gap.
    nv = vcyc.size();
    send_frame(8'h00, 1'b1, 1'b0, a0);
    send_frame(8'hFF, 1'b1, 1'b0, a1);
    drive_bit(1'b1, BIT);
    check("b2b pulse count", vcyc.size() - nv, 2);
    if (vcyc.size() >= nv + 2) begin
      check("b2b spacing", vcyc[nv + 1] - vcyc[nv], FRAME_CYC);
      check("b2b first", vdata[nv], 8'h00);
      check("b2b second", vdata[nv + 1], 8'hFF);
    end

`ifdef UART_RX_PARITY_EN
    // Wrong then correct parity on 0x07.
    nv = vcyc.size();
    np = n_perr;
    send_frame(8'h07, 1'b1, 1'b0, a0);
    drive_bit(1'b1, BIT);
    check("perr count", n_perr - np, 1);
    check("perr no valid", vcyc.size() - nv, 0);
    check("perr data held", rx_data, 8'hFF);
    send_frame(8'h07, 1'b1, 1'b1, a0);
    drive_bit(1'b1, BIT);
    check("parity ok data", rx_data, 8'h07);
`else
    np = n_perr;
`endif

    // Randomised frames against the model.
    for (int k = 0; k < 30; k++) begin
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 7) != 0);
      par_b  = ^d;
`ifdef UART_RX_PARITY_EN
      if ($urandom_range(0, 5) == 0) par_b = ~par_b;
`endif
      send_frame(d, stop_b, par_b, a0);
      gap = stop_b ? $urandom_range(0, 24) : BIT + $urandom_range(0, 20);
      if (gap > 0) drive_bit(1'b1, gap);
    end

    drive_bit(1'b1, 200);
`ifndef UART_RX_PARITY_EN
    check("no parity errors", n_perr - np, 0);
`endif
    check("pending events", evq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
